cia_bus_arbiter: RTL

CIA_BUS_ARBITER -- requirements
Module: cia_bus_arbiter

---
 rtl/cia_bus_arbiter_if.sv | 22 ++
 rtl/cia_bus_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cia_bus_arbiter_if.sv
// Host-side request/response bundle for cia_bus_arbiter.
// The master modport is the host requester; the slave modport is the arbiter.
interface cia_bus_arbiter_if;
   logic       host_req;
   logic       host_rw;
   logic [3:0] host_rs;
   logic [7:0] host_wdata;
   logic       host_ack;
   logic       host_err;
   logic [7:0] host_rdata;
   logic       host_busy;

   modport master (
      output host_req, host_rw, host_rs, host_wdata,
      input  host_ack, host_err, host_rdata, host_busy
   );

   modport slave (
      input  host_req, host_rw, host_rs, host_wdata,
      output host_ack, host_err, host_rdata, host_busy
   );
endinterface

// File: rtl/cia_bus_arbiter.sv
// Shares a CIA register port between the 6502-side CPU (always wins) and a host requester.
// Optional macro CIA_ARB_ICR_GUARD_EN blocks host reads of the read-to-clear ICR (rs=4'hD).
module cia_bus_arbiter #(
   parameter int unsigned STARVE_MAX = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     phi2_p,
   input  logic                     phi2_n,
   input  logic                     cpu_cs_n,
   input  logic                     cpu_rw,
   input  logic [3:0]               cpu_rs,
   input  logic [7:0]               cpu_db,
   cia_bus_arbiter_if.slave         host,
   output logic                     cia_cs_n,
   output logic                     cia_rw,
   output logic [3:0]               cia_rs,
   output logic [7:0]               cia_db_in,
   input  logic [7:0]               cia_db_out
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      ACCESS  = 2'd2,
      CAPTURE = 2'd3
   } state_t;

   // The starvation limit is compared against an 8-bit saturating counter.
   localparam logic [7:0] STARVE_LIM = (STARVE_MAX > 32'd255) ? 8'hFF : 8'(STARVE_MAX);

   state_t     state_r;
   logic [7:0] slot_cnt_r;
   logic       hold_rw_r;
   logic [3:0] hold_rs_r;
   logic [7:0] hold_wdata_r;
   logic       guard_pend_r;

   logic       phi2_n_s;
   logic       cpu_own_s;
   logic       host_own_s;
   logic [7:0] slot_cnt_inc_s;
   logic       starve_s;
   logic       accept_s;
   logic       icr_block_s;

   // Slot ownership, acceptance and starvation decode.
   always_comb begin
      phi2_n_s       = 1'b0;
      cpu_own_s      = 1'b0;
      host_own_s     = 1'b0;
      slot_cnt_inc_s = slot_cnt_r;
      starve_s       = 1'b0;
      accept_s       = 1'b0;
      icr_block_s    = 1'b0;

      phi2_n_s   = phi2_n & ~phi2_p;
      cpu_own_s  = phi2_p & ~cpu_cs_n;
      host_own_s = phi2_p & cpu_cs_n & (state_r == WAIT);

      if (slot_cnt_r == 8'hFF) begin
         slot_cnt_inc_s = slot_cnt_r;
      end else begin
         slot_cnt_inc_s = slot_cnt_r + 8'd1;
      end

      starve_s = (state_r == WAIT) & cpu_own_s & (slot_cnt_inc_s >= STARVE_LIM);
      // A request seen while the previous ack is still high must be re-asserted.
      accept_s = (state_r == IDLE) & host.host_req & ~host.host_ack & ~guard_pend_r;

`ifdef CIA_ARB_ICR_GUARD_EN
      icr_block_s = accept_s & host.host_rw & (host.host_rs == 4'hD);
`else
      icr_block_s = 1'b0;
`endif
   end

   // Host FSM, CIA port drive and host response registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r         <= IDLE;
         slot_cnt_r      <= 8'h00;
         hold_rw_r       <= 1'b1;
         hold_rs_r       <= 4'h0;
         hold_wdata_r    <= 8'h00;
         guard_pend_r    <= 1'b0;
         host.host_ack   <= 1'b0;
         host.host_err   <= 1'b0;
         host.host_rdata <= 8'h00;
         host.host_busy  <= 1'b0;
         cia_cs_n        <= 1'b1;
         cia_rw          <= 1'b1;
         cia_rs          <= 4'h0;
         cia_db_in       <= 8'h00;
      end else begin
         host.host_ack <= 1'b0;
         host.host_err <= 1'b0;

         // With no owner the select and direction release; rs/db keep their last value.
         if (phi2_p) begin
            if (cpu_own_s) begin
               cia_cs_n  <= 1'b0;
               cia_rw    <= cpu_rw;
               cia_rs    <= cpu_rs;
               cia_db_in <= cpu_db;
            end else if (host_own_s) begin
               cia_cs_n  <= 1'b0;
               cia_rw    <= hold_rw_r;
               cia_rs    <= hold_rs_r;
               cia_db_in <= hold_wdata_r;
            end else begin
               cia_cs_n  <= 1'b1;
               cia_rw    <= 1'b1;
            end
         end

         case (state_r)
            IDLE: begin
               if (guard_pend_r) begin
                  guard_pend_r   <= 1'b0;
                  host.host_ack  <= 1'b1;
                  host.host_err  <= 1'b1;
                  host.host_busy <= 1'b0;
               end else if (accept_s) begin
                  hold_rw_r      <= host.host_rw;
                  hold_rs_r      <= host.host_rs;
                  hold_wdata_r   <= host.host_wdata;
                  host.host_busy <= 1'b1;
                  slot_cnt_r     <= 8'h00;
                  if (icr_block_s) begin
                     guard_pend_r <= 1'b1;
                  end else begin
                     state_r <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (host_own_s) begin
                  state_r <= ACCESS;
               end else if (cpu_own_s) begin
                  slot_cnt_r <= slot_cnt_inc_s;
                  if (starve_s) begin
                     state_r        <= IDLE;
                     host.host_ack  <= 1'b1;
                     host.host_err  <= 1'b1;
                     host.host_busy <= 1'b0;
                  end
               end
            end
            ACCESS: begin
               if (phi2_n_s) begin
                  state_r <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (hold_rw_r) begin
                  host.host_rdata <= cia_db_out;
               end
               host.host_ack  <= 1'b1;
               host.host_err  <= 1'b0;
               host.host_busy <= 1'b0;
               state_r        <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
